// File: rtl/weight_pattern_pkg.sv
// Shared encodings and class helpers for the weight pattern generator.
// Classes are defined by the popcount of a 4-bit vector.
package weight_pattern_pkg;

  localparam logic [1:0] MODE_W23  = 2'b00;
  localparam logic [1:0] MODE_W2   = 2'b01;
  localparam logic [1:0] MODE_W3   = 2'b10;
  localparam logic [1:0] MODE_WNOT = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic logic [2:0] popcount4(input logic [3:0] vec);
    popcount4 = 3'(vec[0]) + 3'(vec[1]) + 3'(vec[2]) + 3'(vec[3]);
  endfunction

  function automatic logic in_class(input logic [3:0] vec, input logic [1:0] mode);
    logic [2:0] w;
    w = popcount4(vec);
    case (mode)
      MODE_W23: in_class = (w == 3'd2) || (w == 3'd3);
      MODE_W2:  in_class = (w == 3'd2);
      MODE_W3:  in_class = (w == 3'd3);
      default:  in_class = (w <= 3'd1) || (w == 3'd4);
    endcase
  endfunction

  // Lowest member of the class; descending scan so the smallest hit wins.
  function automatic logic [3:0] first_member(input logic [1:0] mode);
    first_member = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (in_class(4'(i), mode)) first_member = 4'(i);
    end
  endfunction

endpackage

// File: rtl/weight_class_match.sv
// Combinational class lookup: membership, next-higher member and last-member flag
// for a 4-bit index under a given class select.
module weight_class_match
  import weight_pattern_pkg::*;
(
  input  logic [3:0] idx,
  input  logic [1:0] mode,
  output logic       member,
  output logic [3:0] next_idx,
  output logic       is_last
);

  logic found;

  // Priority scan over indices above idx; lowest hit is written last.
  always_comb begin
    next_idx = idx;
    found    = 1'b0;
    for (int i = 15; i >= 1; i--) begin
      if ((4'(i) > idx) && in_class(4'(i), mode)) begin
        next_idx = 4'(i);
        found    = 1'b1;
      end
    end
  end

  assign member  = in_class(idx, mode);
  assign is_last = member & ~found;

endmodule

// File: rtl/weight_pattern_gen.sv
// Enumerates the 4-bit vectors of a popcount class in ascending order over a
// valid/ready handshake, flagging the final member of each pass.
module weight_pattern_gen
  import weight_pattern_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       valid,
  output logic       last,
  output logic       busy,
  output logic       done,
  output logic [3:0] count
);

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] pat_q, pat_d;
  logic [3:0] count_q, count_d;
  logic [3:0] next_idx;
  logic       member;
  logic       is_last;
  logic       handshake;

  weight_class_match u_match (
    .idx      (pat_q),
    .mode     (mode_q),
    .member   (member),
    .next_idx (next_idx),
    .is_last  (is_last)
  );

  // The pattern register only ever holds members in RUN; member keeps valid honest.
  assign valid     = (state_q == RUN) & member;
  assign handshake = valid & ready;
  assign last      = valid & is_last;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign {a, b, c, d} = pat_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          pat_d   = first_member(mode);
          count_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          count_d = count_q + 4'd1;
          if (!is_last) begin
            pat_d = next_idx;
          end else if (WRAP) begin
            pat_d = first_member(mode_q);
          end else begin
            state_d = DONE;
          end
        end
        if (stop) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_W23;
      pat_q   <= 4'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Bench for weight_pattern_gen: two instances (one-pass and wrapping) share stimulus
// and are compared every cycle against a list-based model of the member sequence.
module tb_weight_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, start, stop, ready;
  logic [1:0] mode;
  logic [1:0] a, b, c, d, valid, last, busy, done;
  logic [3:0] count0, count1;

  always #5 clk = ~clk;

  weight_pattern_gen #(.WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .ready(ready),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .valid(valid[0]), .last(last[0]),
    .busy(busy[0]), .done(done[0]), .count(count0)
  );

  weight_pattern_gen #(.WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .ready(ready),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .valid(valid[1]), .last(last[1]),
    .busy(busy[1]), .done(done[1]), .count(count1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance (slot 1 wraps).
  int         m_state[2];  // 0 idle, 1 run, 2 done
  int         m_pos[2];
  int         m_cnt[2];
  logic [1:0] m_mode[2];
  logic [3:0] m_vec[2];
  bit         m_known[2];

  logic [3:0] cap0[$];
  logic [3:0] cap1[$];
  logic [3:0] lastq0[$];

  typedef struct {
    logic [1:0]  mode;
    bit          toggle;
    bit          perturb;
    int          n;
    logic [39:0] seq;
  } pass_t;

  pass_t passes[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit member_of(input int v, input logic [1:0] md);
    int w;
    w = $countones(4'(v));
    case (md)
      2'd0:    return (w == 2) || (w == 3);
      2'd1:    return w == 2;
      2'd2:    return w == 3;
      default: return (w <= 1) || (w == 4);
    endcase
  endfunction

  function automatic int class_size(input logic [1:0] md);
    int n = 0;
    for (int v = 0; v < 16; v++) if (member_of(v, md)) n++;
    return n;
  endfunction

  function automatic int nth_member(input logic [1:0] md, input int k);
    int n = 0;
    for (int v = 0; v < 16; v++) begin
      if (member_of(v, md)) begin
        if (n == k) return v;
        n++;
      end
    end
    return 0;
  endfunction

  function automatic logic [3:0] vec_of(input int w);
    return {a[w], b[w], c[w], d[w]};
  endfunction

  task automatic model_step(input int w);
    int n;
    if (rst) begin
      m_state[w] = 0; m_cnt[w] = 0; m_pos[w] = 0; m_mode[w] = 2'd0;
      m_vec[w] = 4'd0; m_known[w] = 1'b1;
      return;
    end
    case (m_state[w])
      0: begin
        if (start) begin
          m_mode[w] = mode; m_pos[w] = 0; m_cnt[w] = 0; m_state[w] = 1; m_known[w] = 1'b1;
        end
      end
      1: begin
        n = class_size(m_mode[w]);
        if (ready) begin
          m_cnt[w] = (m_cnt[w] + 1) % 16;
          if (m_pos[w] == n - 1) begin
            if (w == 1) m_pos[w] = 0;
            else m_state[w] = 2;
          end else begin
            m_pos[w]++;
          end
        end
        if (stop) begin
          m_state[w] = 0; m_known[w] = 1'b0;
        end
      end
      default: begin
        m_state[w] = 0; m_known[w] = 1'b0;
      end
    endcase
    if (m_state[w] != 0) m_vec[w] = 4'(nth_member(m_mode[w], m_pos[w]));
  endtask

  task automatic model_check(input int w);
    bit ev;
    ev = (m_state[w] == 1);
    chk($sformatf("w%0d valid", w), valid[w], ev);
    chk($sformatf("w%0d last", w), last[w],
        ev && (m_pos[w] == class_size(m_mode[w]) - 1));
    chk($sformatf("w%0d busy", w), busy[w], m_state[w] != 0);
    chk($sformatf("w%0d done", w), done[w], m_state[w] == 2);
    chk($sformatf("w%0d count", w), (w == 0) ? count0 : count1, m_cnt[w]);
    if (m_known[w]) chk($sformatf("w%0d vector", w), vec_of(w), m_vec[w]);
  endtask

  // Capture handshakes before the edge, advance the model on it, check at negedge.
  task automatic tick();
    logic [3:0] v;
    int         f;
    for (int w = 0; w < 2; w++) begin
      if (!rst && valid[w] && ready) begin
        v = vec_of(w);
        if (w == 0) cap0.push_back(v); else cap1.push_back(v);
        if (w == 0 && last[0]) lastq0.push_back(v);
        f = (($countones(v) == 2) || ($countones(v) == 3)) ? 1 : 0;
        chk($sformatf("w%0d detector f", w), f, (m_mode[w] != 2'd3) ? 1 : 0);
      end
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic go_idle();
    stop = 1'b1; start = 1'b0; ready = 1'b0;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic run_pass(input pass_t e);
    int pulses   = 0;
    bit finished = 1'b0;
    go_idle();
    cap0.delete();
    lastq0.delete();
    mode  = e.mode;
    start = 1'b1;
    ready = 1'b1;
    tick();
    if (!e.perturb) start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      ready = e.toggle ? ((k % 2) == 0) : 1'b1;
      if (e.perturb) mode = 2'($urandom);
      tick();
      if (done[0]) begin
        pulses++;
        start = 1'b0;
      end
      if (!busy[0]) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk($sformatf("mode%0d pass finishes", e.mode), finished, 1);
    chk($sformatf("mode%0d vector count", e.mode), cap0.size(), e.n);
    for (int k = 0; k < e.n && k < cap0.size(); k++)
      chk($sformatf("mode%0d vector %0d", e.mode, k), cap0[k], e.seq[k*4 +: 4]);
    chk($sformatf("mode%0d done pulses", e.mode), pulses, 1);
    chk($sformatf("mode%0d final count", e.mode), count0, e.n);
    chk($sformatf("mode%0d last flags", e.mode), lastq0.size(), 1);
    if (lastq0.size() > 0)
      chk($sformatf("mode%0d last vector", e.mode), lastq0[0], e.seq[(e.n-1)*4 +: 4]);
  endtask

  initial begin
    logic [31:0] wrap_seq;
    int          done1_seen;

    passes[0] = '{mode: 2'd0, toggle: 1'b0, perturb: 1'b0, n: 10,
                  seq: {4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3}};
    passes[1] = '{mode: 2'd2, toggle: 1'b1, perturb: 1'b0, n: 4,
                  seq: {24'd0, 4'd14, 4'd13, 4'd11, 4'd7}};
    passes[2] = '{mode: 2'd1, toggle: 1'b0, perturb: 1'b1, n: 6,
                  seq: {16'd0, 4'd12, 4'd10, 4'd9, 4'd6, 4'd5, 4'd3}};
    passes[3] = '{mode: 2'd3, toggle: 1'b0, perturb: 1'b0, n: 6,
                  seq: {16'd0, 4'd15, 4'd8, 4'd4, 4'd2, 4'd1, 4'd0}};

    rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0; mode = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset count", count0, 0);
    chk("reset vector", vec_of(0), 0);

    for (int i = 0; i < 4; i++) run_pass(passes[i]);

    // Wrapping pass in the complement class: 8 handshakes, stop on the 8th.
    go_idle();
    cap1.delete();
    done1_seen = 0;
    mode = 2'd3; start = 1'b1;
    tick();
    start = 1'b0; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) stop = 1'b1;
      tick();
      if (done[1]) done1_seen++;
    end
    stop = 1'b0;
    wrap_seq = {4'd1, 4'd0, 4'd15, 4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
    chk("wrap vector count", cap1.size(), 8);
    for (int k = 0; k < 8 && k < cap1.size(); k++)
      chk($sformatf("wrap vector %0d", k), cap1[k], wrap_seq[k*4 +: 4]);
    chk("wrap no done", done1_seen, 0);
    chk("wrap idle after stop", busy[1], 0);
    chk("wrap count", count1, 8);

    // Reset in the middle of a pass.
    go_idle();
    mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0; ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    chk("mid reset valid", valid[0], 0);
    chk("mid reset busy", busy[0], 0);
    chk("mid reset count", count0, 0);
    chk("mid reset vector", vec_of(0), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart first vector", vec_of(0), 3);
    chk("restart valid", valid[0], 1);

    // Count wraps past 15 on the wrapping instance.
    go_idle();
    mode = 2'd2; start = 1'b1;
    tick();
    start = 1'b0; ready = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    chk("count wrap", count1, 1);

    // Random traffic against the model.
    go_idle();
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(63) == 0);
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(23) == 0);
      mode  = 2'($urandom);
      ready = ($urandom_range(2) != 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_pattern_gen.md
# weight_pattern_gen

Sequential pattern source for the 4-input "two-or-three-high" detector. It enumerates, in ascending order, every 4-bit input vector (a,b,c,d) in a selected popcount class and presents the vectors over a valid/ready handshake. It sits upstream of the detector in self-checking lab benches and board demos, and flags the last vector of each pass.

## Interface
Parameters:
- WRAP, default 0: 0 means one pass then DONE; 1 means restart from the first vector after the last one, until stop.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- stop  in  1  abort; sampled in every non-IDLE state.
- mode  in  2  class select, latched at start. 00: weight 2 or 3. 01: weight 2. 10: weight 3. 11: weight 0, 1 or 4.
- ready  in  1  consumer accepts the current vector.
- a, b, c, d  out  1 each  current vector; a is the MSB of the 4-bit index.
- valid  out  1  vector on a..d is a class member.
- last  out  1  the current vector is the final member of the class.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a non-wrapping pass completes.
- count  out  4  number of accepted handshakes since start, modulo 16.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - valid=0.
  - On start=1: latch mode, load the pattern register with the lowest member of the class, clear count, go to RUN.
- RUN:
  - valid=1, and a..d hold the pattern register.
  - On a handshake (valid & ready): count increments.
  - If the current vector is not the last member, load the next-higher member.
  - If it is the last member and WRAP=0, go to DONE.
  - If it is the last member and WRAP=1, load the lowest member and stay in RUN.
  - Without ready, a..d, valid and last hold steady.
- DONE:
  - done=1 and valid=0 for exactly one cycle, then IDLE.
  - a..d keep the final vector.
- Member orders:
  - Mode 00 (10 members): 3,5,6,7,9,10,11,12,13,14.
  - Mode 01 (6 members): 3,5,6,9,10,12.
  - Mode 10 (4 members): 7,11,13,14.
  - Mode 11 (6 members): 0,1,2,4,8,15.
- last is combinational from the pattern register and the latched mode. It is only meaningful while valid=1 and is 0 otherwise.
- Next-member search is a single-cycle combinational priority scan over the indices above the current one.
- stop in RUN or DONE: go to IDLE next cycle with valid=0, done=0 and no pulse. A handshake in that same cycle still increments count.
- start outside IDLE is ignored; mode changes after start are ignored.
- count wraps 15→0, which is only reachable with WRAP=1.

## Timing
- Reset values: valid=0, last=0, busy=0, done=0, count=0, a=b=c=d=0. State is IDLE.
- rst overrides everything, including mid-pass.
- start at edge t: valid=1 with the first member after edge t (1-cycle latency).
- Handshake at edge k: the next member is presented after edge k (zero bubble, full throughput).
- Final handshake at edge k with WRAP=0: done=1 and busy=1 during the cycle after k. IDLE and busy=0 follow one cycle later. The earliest restart start is then accepted.
- stop and rst have no latency beyond one edge.

## Structure
- The shared package weight_pattern_pkg holds:
  - mode encodings MODE_W23, MODE_W2, MODE_W3, MODE_WNOT.
  - the state enum IDLE/RUN/DONE.
  - a popcount4 function and an in_class(vec, mode) function.
- One natural sub-module is weight_class_match, a combinational block:
  - input: 4-bit index and mode.
  - outputs: member flag, next-higher-member index, is_last flag.
- The top level holds the FSM, the pattern register, count and the handshake.

## Test plan
- Mode 00, WRAP=0, ready tied 1, start pulsed:
  - Required: exactly 10 valid cycles with vectors 3,5,6,7,9,10,11,12,13,14.
  - Required: last=1 only on 14, then done pulse, then count=10.
- Mode 10 with ready toggling 1,0,1,0:
  - Required: vectors 7,11,13,14, each held while ready=0.
  - Required: count=4, and no vector dropped or repeated.
- Mode 11, WRAP=1, 8 handshakes, then stop:
  - Required sequence: 0,1,2,4,8,15,0,1.
  - Required: no done pulse; IDLE one cycle after stop.
- rst asserted after the third handshake in mode 01:
  - Required next cycle: all outputs at reset values and state IDLE.
  - A fresh start then yields 3 first.
- start held high in RUN, and mode changed mid-pass:
  - Required: sequence unaffected.
  - A new pass begins only from IDLE.
- Scoreboard check: every emitted vector, applied to the detector, yields f=1 for modes 00/01/10 and f=0 for mode 11.
